// File: rtl/brlite_local_bridge.sv
// brlite_local_bridge: BrLite local-port endpoint facing the DMNI NI service port.
//
// TX path: accepts one held NI broadcast request, stamps it with {seq, src_id},
//   presents it to the router local input and pulses ni_ack_o once the router accepts it.
// RX path: buffers router deliveries in an RX_DEPTH-entry FIFO, presents the head to the NI
//   and pops on an ni_ack_i pulse.
//
// Payload layout (36 bits): [35:32] ksvc, [31:16] seq_source {seq[7:0], src[7:0]},
//   [15:0] payload.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   ni_req_i / ni_ack_o     NI send request (level) / accept pulse
//   ni_data_i               NI send payload (seq_source field ignored)
//   ni_busy_o               TX FSM not idle
//   ni_rx_o / ni_ack_i      RX FIFO not empty / NI consumed head (pulse)
//   ni_data_o               RX FIFO head, valid while ni_rx_o
//   rt_req_o / rt_ack_i     request to router local input / router accepted
//   rt_data_o               stamped outgoing broadcast
//   rt_req_i / rt_ack_o     router delivery (held) / accept-or-drop pulse
//   rt_data_i               delivered broadcast
//
// Build option: define BRLITE_SELF_FILTER_EN to ack-and-drop deliveries whose source equals
//   this PE's src_id (own broadcast echo). Undefined: every delivery is buffered.

module brlite_local_bridge #(
  parameter logic [15:0] ADDRESS  = 16'h0000,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ni_req_i,
  output logic        ni_ack_o,
  input  logic [35:0] ni_data_i,
  output logic        ni_busy_o,
  output logic        ni_rx_o,
  input  logic        ni_ack_i,
  output logic [35:0] ni_data_o,
  output logic        rt_req_o,
  input  logic        rt_ack_i,
  output logic [35:0] rt_data_o,
  input  logic        rt_req_i,
  output logic        rt_ack_o,
  input  logic [35:0] rt_data_i
);

  localparam int unsigned PtrW = $clog2(RX_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Source id packs the low nibbles of x and y.
  localparam logic [7:0] SrcId = {ADDRESS[11:8], ADDRESS[3:0]};

  // ---------------------------------------------------------------------------
  // TX FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {StIdle, StLatch, StReq, StAck, StHold} tx_state_e;

  tx_state_e   state_q;
  logic [7:0]  seq_q;
  logic        rt_req_q;
  logic        ni_ack_q;
  logic        busy_q;
  logic [35:0] rt_data_q;

  // The NI's seq_source field is overwritten by the stamp.
  logic [15:0] unused_ni_seq_source;
  assign unused_ni_seq_source = ni_data_i[31:16];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      seq_q     <= 8'h00;
      rt_req_q  <= 1'b0;
      ni_ack_q  <= 1'b0;
      busy_q    <= 1'b0;
      rt_data_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (ni_req_i) begin
            state_q <= StLatch;
            busy_q  <= 1'b1;
          end
        end
        StLatch: begin
          rt_data_q <= {ni_data_i[35:32], seq_q, SrcId, ni_data_i[15:0]};
          rt_req_q  <= 1'b1;
          state_q   <= StReq;
        end
        StReq: begin
          if (rt_ack_i) begin
            rt_req_q <= 1'b0;
            ni_ack_q <= 1'b1;
            seq_q    <= seq_q + 8'd1;
            state_q  <= StAck;
          end
        end
        StAck: begin
          ni_ack_q <= 1'b0;
          state_q  <= StHold;
        end
        StHold: begin
          // Wait for the NI to drop its level request so one request yields one send.
          if (!ni_req_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q  <= StIdle;
          rt_req_q <= 1'b0;
          ni_ack_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rt_req_o  = rt_req_q;
  assign rt_data_o = rt_data_q;
  assign ni_ack_o  = ni_ack_q;
  assign ni_busy_o = busy_q;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [35:0]     mem_q [RX_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            rt_ack_q;
  logic [35:0]     head_q, head_d;

  logic pop, push, accept, full, drop;

`ifdef BRLITE_SELF_FILTER_EN
  assign drop = (rt_data_i[23:16] == SrcId);
`else
  assign drop = 1'b0;
`endif

  always_comb begin
    pop    = ni_ack_i && (count_q != '0);
    full   = (count_q == CntW'(RX_DEPTH));
    // A delivery is taken once per handshake; dropped echoes need no free slot.
    accept = rt_req_i && !rt_ack_q && (drop || !full || pop);
    push   = accept && !drop;

    count_d  = count_q + CntW'(push) - CntW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    // Next head: if no old entry survives the pop, the head is whatever is pushed now.
    if (count_q == CntW'(pop)) begin
      head_d = push ? rt_data_i : '0;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= rt_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rt_ack_q <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rt_ack_q <= accept;
      head_q   <= head_d;
    end
  end

  assign rt_ack_o  = rt_ack_q;
  assign ni_rx_o   = (count_q != '0);
  assign ni_data_o = head_q;

endmodule

// File: tb/tb_brlite_local_bridge.sv
// Directed testbench for brlite_local_bridge (ADDRESS=16'h0102, RX_DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_brlite_local_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ni_req_i, ni_ack_o, ni_busy_o, ni_rx_o, ni_ack_i;
  logic [35:0] ni_data_i, ni_data_o;
  logic        rt_req_o, rt_ack_i, rt_req_i, rt_ack_o;
  logic [35:0] rt_data_o, rt_data_i;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  brlite_local_bridge #(
    .ADDRESS  (16'h0102),
    .RX_DEPTH (4)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .ni_req_i  (ni_req_i),
    .ni_ack_o  (ni_ack_o),
    .ni_data_i (ni_data_i),
    .ni_busy_o (ni_busy_o),
    .ni_rx_o   (ni_rx_o),
    .ni_ack_i  (ni_ack_i),
    .ni_data_o (ni_data_o),
    .rt_req_o  (rt_req_o),
    .rt_ack_i  (rt_ack_i),
    .rt_data_o (rt_data_o),
    .rt_req_i  (rt_req_i),
    .rt_ack_o  (rt_ack_o),
    .rt_data_i (rt_data_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic logic [35:0] item(input int k);
    item = {4'h3, 16'h0A33, 16'h1000 + 16'(k)};
  endfunction

  // One NI send; router acks in the 3rd REQ cycle. hold_extra keeps ni_req_i high after ack.
  task automatic send(input logic [15:0] exp_ss, input bit full_chk, input int hold_extra);
    int cyc;
    ni_data_i = {4'h5, 16'hA5A5, 16'hBEEF};
    ni_req_i  = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!rt_req_o && cyc < 20);
    chk("tx_req_rise", rt_req_o, 1);
    chk("tx_data", rt_data_o, {4'h5, exp_ss, 16'hBEEF});
    if (full_chk) begin
      chk("tx_latency", cyc, 2);
      chk("tx_busy", ni_busy_o, 1);
    end
    repeat (2) begin
      tick();
      if (full_chk) chk("tx_req_held", rt_req_o, 1);
    end
    if (full_chk) chk("ni_ack_early", ni_ack_o, 0);
    rt_ack_i = 1'b1;
    tick();
    rt_ack_i = 1'b0;
    chk("ni_ack_pulse", ni_ack_o, 1);
    if (full_chk) chk("tx_req_drop", rt_req_o, 0);
    tick();
    chk("ni_ack_single", ni_ack_o, 0);
    for (int i = 0; i < hold_extra; i++) begin
      tick();
      chk("no_double_send", rt_req_o, 0);
      chk("hold_busy", ni_busy_o, 1);
    end
    ni_req_i = 1'b0;
    tick();
    chk("tx_idle", ni_busy_o, 0);
  endtask

  task automatic deliver(input logic [35:0] d);
    int cyc;
    rt_data_i = d;
    rt_req_i  = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!rt_ack_o && cyc < 20);
    chk("rx_ack_latency", cyc, 1);
    rt_req_i = 1'b0;
    tick();
    chk("rx_ack_single", rt_ack_o, 0);
  endtask

  task automatic pop(input logic [35:0] exp);
    chk("rx_valid", ni_rx_o, 1);
    chk("rx_head", ni_data_o, exp);
    ni_ack_i = 1'b1;
    tick();
    ni_ack_i = 1'b0;
  endtask

  initial begin
    int cyc;
    rst_ni    = 1'b0;
    ni_req_i  = 1'b0;
    ni_ack_i  = 1'b0;
    ni_data_i = '0;
    rt_ack_i  = 1'b0;
    rt_req_i  = 1'b0;
    rt_data_i = '0;
    #12;
    chk("rst_rt_req", rt_req_o, 0);
    chk("rst_ni_ack", ni_ack_o, 0);
    chk("rst_busy", ni_busy_o, 0);
    chk("rst_rx", ni_rx_o, 0);
    chk("rst_rt_ack", rt_ack_o, 0);
    chk("rst_ni_data", ni_data_o, 0);
    chk("rst_rt_data", rt_data_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Basic sends: seq 0 then 1, src 8'h12.
    send(16'h0012, 1'b1, 0);
    send(16'h0112, 1'b1, 0);

    // Sequence wrap: seq 2..255, then 0 again; hold ni_req_i after ack on that one.
    for (int s = 2; s < 256; s++) begin
      send({8'(s), 8'h12}, 1'b0, 0);
    end
    send(16'h0012, 1'b1, 4);
    send(16'h0112, 1'b1, 0);

    // RX fill: 4 accepted, 5th held until one pop.
    for (int k = 1; k <= 4; k++) deliver(item(k));
    chk("rx_nonempty", ni_rx_o, 1);
    rt_data_i = item(5);
    rt_req_i  = 1'b1;
    repeat (4) begin
      tick();
      chk("rx_full_hold", rt_ack_o, 0);
    end
    chk("rx_full_head", ni_data_o, item(1));
    ni_ack_i = 1'b1;
    tick();
    ni_ack_i = 1'b0;
    chk("rx_5th_ack", rt_ack_o, 1);
    rt_req_i = 1'b0;
    tick();
    for (int k = 2; k <= 5; k++) pop(item(k));
    chk("rx_drained", ni_rx_o, 0);

    // Push + pop on a full FIFO: count stays 4, order preserved.
    for (int k = 11; k <= 14; k++) deliver(item(k));
    rt_data_i = item(15);
    rt_req_i  = 1'b1;
    ni_ack_i  = 1'b1;
    tick();
    ni_ack_i = 1'b0;
    rt_req_i = 1'b0;
    chk("pp_ack", rt_ack_o, 1);
    chk("pp_head", ni_data_o, item(12));
    rt_data_i = item(16);
    rt_req_i  = 1'b1;
    repeat (3) begin
      tick();
      chk("pp_still_full", rt_ack_o, 0);
    end
    rt_req_i = 1'b0;
    tick();
    for (int k = 12; k <= 15; k++) pop(item(k));
    chk("pp_drained", ni_rx_o, 0);

    // Own-echo delivery.
    deliver({4'h7, 16'h0712, 16'h5555});
`ifdef BRLITE_SELF_FILTER_EN
    chk("filter_drop", ni_rx_o, 0);
`else
    chk("filter_keep", ni_rx_o, 1);
    pop({4'h7, 16'h0712, 16'h5555});
    chk("filter_drained", ni_rx_o, 0);
`endif

    // Async reset while in REQ with two entries buffered.
    deliver(item(21));
    deliver(item(22));
    ni_data_i = {4'h5, 16'h0000, 16'hBEEF};
    ni_req_i  = 1'b1;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!rt_req_o && cyc < 20);
    chk("mid_req", rt_req_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_rt_req", rt_req_o, 0);
    chk("arst_rx", ni_rx_o, 0);
    chk("arst_busy", ni_busy_o, 0);
    chk("arst_ni_data", ni_data_o, 0);
    tick();
    ni_req_i = 1'b0;
    rst_ni   = 1'b1;
    tick();
    chk("post_rst_idle", ni_busy_o, 0);
    // Sequence restarts at 0 after reset.
    send(16'h0012, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
